// File: rtl/l15_data_ram_initiator.sv
// Sole master of the L1.5 icache data RAM port: streams refill beats into
// consecutive line words and serves single-word lookup reads when no refill runs.
module l15_data_ram_initiator #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 7,
  parameter int BEATS_PER_LINE = 4,
  parameter int BE_WIDTH       = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  refill_req_i,
  input  logic [ADDR_WIDTH-1:0] refill_addr_i,
  output logic                  refill_gnt_o,
  input  logic                  refill_valid_i,
  input  logic [DATA_WIDTH-1:0] refill_data_i,
  output logic                  refill_ready_o,
  output logic                  refill_done_o,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rd_gnt_o,
  output logic                  rd_rvalid_o,
  output logic [DATA_WIDTH-1:0] rd_rdata_o,
  output logic                  ram_req_o,
  output logic                  ram_write_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  output logic [BE_WIDTH-1:0]   ram_be_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  output logic                  dbg_state_o
);

  // Handshakes: a refill beat transfers when refill_valid_i & refill_ready_o;
  // a read transfers when rd_req_i & rd_gnt_o and returns one cycle later with
  // rd_rvalid_o; a refill starts when refill_req_i & refill_gnt_o.

  localparam int CW = $clog2(BEATS_PER_LINE);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(BEATS_PER_LINE - 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS_PER_LINE - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_cnt;
  logic [ADDR_WIDTH-1:0] r_base;
  logic                  r_rvalid;
  logic                  r_done;
  logic                  w_last;

  always_comb begin
    w_next         = r_state;
    w_last         = 1'b0;
    rd_gnt_o       = 1'b0;
    refill_gnt_o   = 1'b0;
    refill_ready_o = 1'b0;
    ram_req_o      = 1'b0;
    ram_write_o    = 1'b0;
    ram_addr_o     = rd_addr_i;
    ram_wdata_o    = '0;
    ram_be_o       = '0;
    case (r_state)
      S_IDLE: begin
        rd_gnt_o     = rd_req_i;
        ram_req_o    = rd_req_i;
        refill_gnt_o = 1'b1;
        if (refill_req_i) w_next = S_FILL;
      end
      S_FILL: begin
        refill_ready_o = 1'b1;
        ram_req_o      = refill_valid_i;
        ram_write_o    = 1'b1;
        // Base has its low bits cleared, so OR never carries into the next line.
        ram_addr_o     = r_base | ADDR_WIDTH'(r_cnt);
        ram_wdata_o    = refill_data_i;
        ram_be_o       = '1;
        w_last         = refill_valid_i && (r_cnt == LAST_BEAT);
        if (w_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_base   <= '0;
      r_rvalid <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_rvalid <= rd_gnt_o;
      r_done   <= w_last;
      if (r_state == S_IDLE && refill_req_i) begin
        r_base <= refill_addr_i & ~LINE_MASK;
        r_cnt  <= '0;
      end else if (r_state == S_FILL && refill_valid_i) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign rd_rvalid_o   = r_rvalid;
  assign rd_rdata_o    = ram_rdata_i;
  assign refill_done_o = r_done;
  assign dbg_state_o   = (r_state == S_FILL);

endmodule

// File: tb/tb_l15_data_ram_initiator.sv
// Bench for l15_data_ram_initiator: RAM model behind the port, shadow memory as
// reference, expected-response queues drained by a negedge monitor.
module tb_l15_data_ram_initiator;

  localparam int DW = 64;
  localparam int AW = 7;
  localparam int NB = 4;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          refill_req_i;
  logic [AW-1:0] refill_addr_i;
  logic          refill_gnt_o;
  logic          refill_valid_i;
  logic [DW-1:0] refill_data_i;
  logic          refill_ready_o;
  logic          refill_done_o;
  logic          rd_req_i;
  logic [AW-1:0] rd_addr_i;
  logic          rd_gnt_o;
  logic          rd_rvalid_o;
  logic [DW-1:0] rd_rdata_o;
  logic          ram_req_o;
  logic          ram_write_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_wdata_o;
  logic [BW-1:0] ram_be_o;
  logic [DW-1:0] ram_rdata_i;
  logic          dbg_state_o;

  l15_data_ram_initiator #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BEATS_PER_LINE(NB)
  ) dut (
    .clk(clk), .rst(rst),
    .refill_req_i(refill_req_i), .refill_addr_i(refill_addr_i),
    .refill_gnt_o(refill_gnt_o), .refill_valid_i(refill_valid_i),
    .refill_data_i(refill_data_i), .refill_ready_o(refill_ready_o),
    .refill_done_o(refill_done_o), .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i),
    .rd_gnt_o(rd_gnt_o), .rd_rvalid_o(rd_rvalid_o), .rd_rdata_o(rd_rdata_o),
    .ram_req_o(ram_req_o), .ram_write_o(ram_write_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_be_o(ram_be_o), .ram_rdata_i(ram_rdata_i),
    .dbg_state_o(dbg_state_o)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model behind the port
  logic [DW-1:0] ram_mem [2**AW];
  always @(posedge clk) begin
    if (ram_req_o) begin
      if (ram_write_o) begin
        for (int b = 0; b < BW; b++)
          if (ram_be_o[b]) ram_mem[ram_addr_o][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
      end else begin
        ram_rdata_i <= ram_mem[ram_addr_o];
      end
    end
  end

  // reference model and scoreboard
  logic [DW-1:0]    ref_mem [2**AW];
  logic [AW+DW-1:0] wr_q[$];
  logic [DW-1:0]    rd_q[$];
  int               rd_cyc_q[$];
  int               done_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [DW-1:0] init_word(input int i);
    return 64'hC0DE_5EED_0000_0000 | 64'(i);
  endfunction

  task automatic chk(input string name, input logic [AW+DW:0] act, input logic [AW+DW:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event with empty expected queue (cycle %0d)", name, cyc);
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (ram_req_o === 1'b1 && ram_write_o === 1'b1) begin
        if (wr_q.size() == 0) unexpected("ram_write");
        else begin
          logic [AW+DW-1:0] e;
          e = wr_q.pop_front();
          chk("ram_waddr", ram_addr_o, e[AW+DW-1:DW]);
          chk("ram_wdata", ram_wdata_o, e[DW-1:0]);
          chk("ram_be", ram_be_o, {BW{1'b1}});
        end
      end
      if (rd_rvalid_o === 1'b1) begin
        if (rd_q.size() == 0) unexpected("rd_rvalid");
        else begin
          chk("rd_rdata", rd_rdata_o, rd_q.pop_front());
          chk("rd_latency", cyc, rd_cyc_q.pop_front());
        end
      end
      if (refill_done_o === 1'b1) begin
        if (done_q.size() == 0) unexpected("refill_done");
        else chk("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_zero();
    refill_req_i   = 1'b0;
    refill_addr_i  = '0;
    refill_valid_i = 1'b0;
    refill_data_i  = '0;
    rd_req_i       = 1'b0;
    rd_addr_i      = '0;
  endtask

  task automatic idle_cycle();
    tick();
    drive_zero();
    @(negedge clk);
    chk("idle_refill_gnt", refill_gnt_o, 1'b1);
    chk("idle_ram_req", ram_req_o, 1'b0);
  endtask

  task automatic read(input logic [AW-1:0] a);
    tick();
    drive_zero();
    rd_req_i  = 1'b1;
    rd_addr_i = a;
    rd_q.push_back(ref_mem[a]);
    rd_cyc_q.push_back(cyc + 1);
    @(negedge clk);
    chk("rd_gnt", rd_gnt_o, 1'b1);
    chk("rd_ram_access", {ram_req_o, ram_write_o, ram_addr_o}, {1'b1, 1'b0, a});
  endtask

  // Request cycle, then beats; pat gives the valid pattern LSB-first for
  // pat_len cycles, after that valid is random with bubble_pct bubbles.
  // rd_req is held throughout when hold_rd is set (granted only in the request cycle).
  task automatic refill(input logic [AW-1:0] addr, input logic [31:0] pat, input int pat_len,
                        input int bubble_pct, input bit hold_rd, input logic [AW-1:0] rd_a);
    logic [AW-1:0] base;
    int beat;
    int i;
    base = addr & ~AW'(NB - 1);
    tick();
    drive_zero();
    refill_req_i  = 1'b1;
    refill_addr_i = addr;
    rd_req_i      = hold_rd;
    rd_addr_i     = rd_a;
    if (hold_rd) begin
      rd_q.push_back(ref_mem[rd_a]);
      rd_cyc_q.push_back(cyc + 1);
    end
    @(negedge clk);
    chk("refill_gnt", refill_gnt_o, 1'b1);
    chk("req_cycle_rd_gnt", rd_gnt_o, hold_rd);
    beat = 0;
    i = 0;
    while (beat < NB) begin
      tick();
      refill_req_i  = 1'($urandom_range(0, 1));
      refill_addr_i = AW'($urandom);
      rd_req_i      = hold_rd;
      rd_addr_i     = rd_a;
      if (i < pat_len) refill_valid_i = pat[i];
      else if (i > 40) refill_valid_i = 1'b1;
      else refill_valid_i = ($urandom_range(0, 99) >= bubble_pct);
      refill_data_i = {$urandom, $urandom};
      if (refill_valid_i) begin
        wr_q.push_back({base + AW'(beat), refill_data_i});
        ref_mem[base + AW'(beat)] = refill_data_i;
        if (beat == NB - 1) done_q.push_back(cyc + 1);
      end
      @(negedge clk);
      chk("fill_ready", refill_ready_o, 1'b1);
      chk("fill_refill_gnt", refill_gnt_o, 1'b0);
      chk("fill_rd_gnt", rd_gnt_o, 1'b0);
      chk("fill_ram_req", ram_req_o, refill_valid_i);
      if (refill_valid_i) beat++;
      i++;
    end
  endtask

  // main sequence
  initial begin
    for (int k = 0; k < 2**AW; k++) begin
      ram_mem[k] = init_word(k);
      ref_mem[k] = init_word(k);
    end
    ram_rdata_i = '0;
    drive_zero();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_rvalid", rd_rvalid_o, 1'b0);
    chk("rst_done", refill_done_o, 1'b0);
    chk("rst_ready", refill_ready_o, 1'b0);
    chk("rst_refill_gnt", refill_gnt_o, 1'b1);
    chk("rst_ram_req", ram_req_o, 1'b0);
    tick();
    rst = 1'b0;

    // back-to-back refill, then reads of the new line
    refill(7'h13, 32'hF, 4, 0, 1'b0, '0);
    idle_cycle();
    read(7'h12);
    read(7'h10);
    read(7'h13);
    idle_cycle();

    // bubbled refill at the top line
    refill(7'h7C, 32'h59, 7, 0, 1'b0, '0);
    idle_cycle();
    read(7'h7F);
    read(7'h7C);
    read(7'h00);

    // contention: read held through the whole refill, re-granted in the done cycle
    refill(7'h41, 32'h0, 0, 30, 1'b1, 7'h42);
    read(7'h42);
    idle_cycle();

    // reset after two of four beats
    refill(7'h55, 32'h0, 0, 0, 1'b0, '0);
    idle_cycle();
    tick();
    drive_zero();
    refill_req_i  = 1'b1;
    refill_addr_i = 7'h31;
    @(negedge clk);
    chk("mid_refill_gnt", refill_gnt_o, 1'b1);
    for (int b = 0; b < 2; b++) begin
      tick();
      drive_zero();
      refill_valid_i = 1'b1;
      refill_data_i  = {$urandom, $urandom};
      wr_q.push_back({7'h30 + 7'(b), refill_data_i});
      ref_mem[7'h30 + 7'(b)] = refill_data_i;
      @(negedge clk);
    end
    tick();
    drive_zero();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_refill_gnt", refill_gnt_o, 1'b1);
    chk("post_rst_ready", refill_ready_o, 1'b0);
    chk("post_rst_done", refill_done_o, 1'b0);
    refill(7'h22, 32'hF, 4, 0, 1'b0, '0);
    idle_cycle();
    for (int k = 0; k < 4; k++) read(7'h20 + 7'(k));
    read(7'h31);

    // random mix
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0: refill(AW'($urandom), 32'h0, 0, 40, 1'($urandom_range(0, 1)), AW'($urandom));
        1, 2: read(AW'($urandom));
        default: idle_cycle();
      endcase
    end

    for (int k = 0; k < 3; k++) idle_cycle();
    chk("wr_q_drained", wr_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
